// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, ALU selects,
// FSM states and datapath mux encodings.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_ORR  = 4'h3;
    localparam logic [3:0] OP_XORR = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_NOTI = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hB;

    localparam logic [2:0] ALU_IDLE  = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_NOT   = 3'd5;
    localparam logic [2:0] ALU_PASSB = 3'd6;

    localparam logic PC_SRC_SEQ = 1'b0;
    localparam logic PC_SRC_TGT = 1'b1;
    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM_RD = 3'd4,
        ST_MEM_WR = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    // States that hold a memory request open and are guarded by the watchdog.
    function automatic logic is_wait_state(input state_e s);
        logic w;
        case (s)
            ST_FETCH, ST_MEM_RD, ST_MEM_WR: w = 1'b1;
            default:                        w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath, decoder and memory port (slave).
interface multicycle_ctrl_if #(
    parameter int OPW  = 4,
    parameter int ALUW = 4
);
    logic [OPW-1:0]  opcode;
    logic            zero;
    logic            mem_ready;
    logic            resume;
    logic [ALUW-1:0] alu_op;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            reg_write;
    logic            pc_write;
    logic            pc_src;
    logic            wb_sel;
    logic            halted;
    logic            illegal;
    logic            mem_err;

    modport master (
        input  opcode, zero, mem_ready, resume,
        output alu_op, mem_read, mem_write, ir_write, reg_write, pc_write,
               pc_src, wb_sel, halted, illegal, mem_err
    );

    modport slave (
        output opcode, zero, mem_ready, resume,
        input  alu_op, mem_read, mem_write, ir_write, reg_write, pc_write,
               pc_src, wb_sel, halted, illegal, mem_err
    );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Watchdog for memory handshakes: counts cycles without mem_ready and flags
// expiry once MEM_TIMEOUT idle cycles have elapsed (0 disables it).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic wait_en,
    input  logic ready,
    output logic expired
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] cnt_r;
    logic          expired_s;

    // Wait counter, saturating at the limit so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (wait_en && !ready && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A ready in the same cycle as the limit completes the access instead.
    always_comb begin
        expired_s = 1'b0;
        if ((MEM_TIMEOUT != 0) && wait_en && !ready && (cnt_r == LIMIT)) begin
            expired_s = 1'b1;
        end else begin
            expired_s = 1'b0;
        end
    end

    assign expired = expired_s;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit CPU: sequences FETCH/DECODE/EXEC/MEM/WB,
// handles memory wait states with a watchdog, branches, HALT and bad opcodes.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int ALUW        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    state_e          state_r, state_next_s;
    logic [OPW-1:0]  op_q_r;
    logic [3:0]      op4_s;
    logic            legal_s;
    logic            expired_s;

    logic [ALUW-1:0] alu_op_s;
    logic            mem_read_s, mem_write_s, ir_write_s, reg_write_s, pc_write_s;
    logic            pc_src_s, wb_sel_s, halted_s, illegal_s, mem_err_s;

    assign op4_s   = op_q_r[3:0];
    assign legal_s = (op_q_r <= OPW'(OP_HLT));

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_next_s != state_r),
        .wait_en (is_wait_state(state_r)),
        .ready   (bus.mem_ready),
        .expired (expired_s)
    );

    // State register and opcode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_q_r  <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_DECODE) begin
                op_q_r <= bus.opcode;
            end else begin
                op_q_r <= op_q_r;
            end
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        alu_op_s     = ALUW'(ALU_IDLE);
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = PC_SRC_SEQ;
        wb_sel_s     = WB_SEL_ALU;
        halted_s     = 1'b0;
        illegal_s    = 1'b0;
        mem_err_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    mem_read_s   = 1'b1;
                    ir_write_s   = 1'b1;
                    state_next_s = ST_DECODE;
                end else if (expired_s) begin
                    mem_err_s    = 1'b1;
                    state_next_s = ST_HALT;
                end else begin
                    mem_read_s   = 1'b1;
                end
            end
            ST_DECODE: begin
                state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (!legal_s) begin
                    pc_write_s   = 1'b1;
                    illegal_s    = 1'b1;
                    state_next_s = ST_FETCH;
                end else begin
                    case (op4_s)
                        OP_ADD:  begin alu_op_s = ALUW'(ALU_ADD);   state_next_s = ST_WB; end
                        OP_SUB:  begin alu_op_s = ALUW'(ALU_SUB);   state_next_s = ST_WB; end
                        OP_ORR:  begin alu_op_s = ALUW'(ALU_OR);    state_next_s = ST_WB; end
                        OP_XORR: begin alu_op_s = ALUW'(ALU_XOR);   state_next_s = ST_WB; end
                        OP_NOTI: begin alu_op_s = ALUW'(ALU_NOT);   state_next_s = ST_WB; end
                        OP_LDI:  begin alu_op_s = ALUW'(ALU_PASSB); state_next_s = ST_WB; end
                        OP_LD:   state_next_s = ST_MEM_RD;
                        OP_ST:   state_next_s = ST_MEM_WR;
                        OP_JMP: begin
                            pc_write_s   = 1'b1;
                            pc_src_s     = PC_SRC_TGT;
                            state_next_s = ST_FETCH;
                        end
                        OP_BEQ: begin
                            alu_op_s     = ALUW'(ALU_SUB);
                            pc_write_s   = 1'b1;
                            pc_src_s     = bus.zero;
                            state_next_s = ST_FETCH;
                        end
                        OP_HLT:  state_next_s = ST_HALT;
                        OP_NOP: begin
                            pc_write_s   = 1'b1;
                            state_next_s = ST_FETCH;
                        end
                        default: begin
                            pc_write_s   = 1'b1;
                            illegal_s    = 1'b1;
                            state_next_s = ST_FETCH;
                        end
                    endcase
                end
            end
            ST_MEM_RD: begin
                if (bus.mem_ready) begin
                    mem_read_s   = 1'b1;
                    wb_sel_s     = WB_SEL_MEM;
                    state_next_s = ST_WB;
                end else if (expired_s) begin
                    mem_err_s    = 1'b1;
                    state_next_s = ST_HALT;
                end else begin
                    mem_read_s   = 1'b1;
                end
            end
            ST_MEM_WR: begin
                if (bus.mem_ready) begin
                    mem_write_s  = 1'b1;
                    pc_write_s   = 1'b1;
                    state_next_s = ST_FETCH;
                end else if (expired_s) begin
                    mem_err_s    = 1'b1;
                    state_next_s = ST_HALT;
                end else begin
                    mem_write_s  = 1'b1;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                pc_write_s   = 1'b1;
                wb_sel_s     = (op4_s == OP_LD) ? WB_SEL_MEM : WB_SEL_ALU;
                state_next_s = ST_FETCH;
            end
            ST_HALT: begin
                halted_s = 1'b1;
                if (bus.resume) begin
                    pc_write_s   = 1'b1;
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign bus.alu_op    = alu_op_s;
    assign bus.mem_read  = mem_read_s;
    assign bus.mem_write = mem_write_s;
    assign bus.ir_write  = ir_write_s;
    assign bus.reg_write = reg_write_s;
    assign bus.pc_write  = pc_write_s;
    assign bus.pc_src    = pc_src_s;
    assign bus.wb_sel    = wb_sel_s;
    assign bus.halted    = halted_s;
    assign bus.illegal   = illegal_s;
    assign bus.mem_err   = mem_err_s;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the full control vector against hand-computed values.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.OPW(4), .ALUW(4)) bus ();

    multicycle_ctrl #(.OPW(4), .ALUW(4), .MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Vector layout: {alu_op[3:0], mem_read, mem_write, ir_write, reg_write,
    //                 pc_write, pc_src, wb_sel, halted, illegal, mem_err}
    wire [13:0] outs_w = {bus.alu_op, bus.mem_read, bus.mem_write, bus.ir_write,
                          bus.reg_write, bus.pc_write, bus.pc_src, bus.wb_sel,
                          bus.halted, bus.illegal, bus.mem_err};

    localparam logic [13:0] E_NONE    = 14'h0000;
    localparam logic [13:0] E_F_OK    = 14'h0280;
    localparam logic [13:0] E_F_WAIT  = 14'h0200;
    localparam logic [13:0] E_WB_ALU  = 14'h0060;
    localparam logic [13:0] E_WB_LD   = 14'h0068;
    localparam logic [13:0] E_RD_WAIT = 14'h0200;
    localparam logic [13:0] E_RD_OK   = 14'h0208;
    localparam logic [13:0] E_WR_WAIT = 14'h0100;
    localparam logic [13:0] E_WR_OK   = 14'h0120;
    localparam logic [13:0] E_JMP     = 14'h0030;
    localparam logic [13:0] E_BEQ_T   = 14'h0830;
    localparam logic [13:0] E_BEQ_N   = 14'h0820;
    localparam logic [13:0] E_NOP     = 14'h0020;
    localparam logic [13:0] E_ILL     = 14'h0022;
    localparam logic [13:0] E_HALT    = 14'h0004;
    localparam logic [13:0] E_RESUME  = 14'h0024;
    localparam logic [13:0] E_MEMERR  = 14'h0001;
    localparam logic [13:0] E_ADD     = 14'h0400;
    localparam logic [13:0] E_SUB     = 14'h0800;
    localparam logic [13:0] E_OR      = 14'h0C00;
    localparam logic [13:0] E_XOR     = 14'h1000;
    localparam logic [13:0] E_NOT     = 14'h1400;
    localparam logic [13:0] E_PASSB   = 14'h1800;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, sample mid-cycle.
    task automatic cyc(input string tag, input logic rdy, input logic z,
                       input logic res, input logic [13:0] exp);
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.resume    = res;
        #2;
        check_eq(tag, {18'd0, outs_w}, {18'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [3:0] op);
        bus.opcode = op;
        cyc({tag, "_fetch"}, 1'b1, 1'b0, 1'b0, E_F_OK);
        cyc({tag, "_decode"}, 1'b1, 1'b1, 1'b1, E_NONE);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 4'h0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        bus.resume    = 1'b0;

        @(posedge clk);
        #1;
        check_eq("in_reset", {18'd0, outs_w}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("idle", 1'b1, 1'b0, 1'b0, E_NONE);

        fetch_decode("add", 4'h1);
        cyc("add_exec", 1'b1, 1'b0, 1'b0, E_ADD);
        cyc("add_wb", 1'b1, 1'b0, 1'b0, E_WB_ALU);

        // LD with one fetch wait and three memory wait states
        bus.opcode = 4'h5;
        cyc("ld_fetch_wait", 1'b0, 1'b0, 1'b0, E_F_WAIT);
        fetch_decode("ld", 4'h5);
        cyc("ld_exec", 1'b1, 1'b0, 1'b0, E_NONE);
        for (int i = 0; i < 3; i++) cyc("ld_rd_wait", 1'b0, 1'b0, 1'b0, E_RD_WAIT);
        cyc("ld_rd_done", 1'b1, 1'b0, 1'b0, E_RD_OK);
        cyc("ld_wb", 1'b1, 1'b0, 1'b0, E_WB_LD);

        fetch_decode("beq1", 4'h8);
        cyc("beq_taken", 1'b1, 1'b1, 1'b0, E_BEQ_T);
        fetch_decode("beq0", 4'h8);
        cyc("beq_not_taken", 1'b1, 1'b0, 1'b0, E_BEQ_N);
        fetch_decode("jmp", 4'h7);
        cyc("jmp_exec", 1'b1, 1'b0, 1'b0, E_JMP);
        fetch_decode("nop", 4'h0);
        cyc("nop_exec", 1'b1, 1'b1, 1'b0, E_NOP);
        fetch_decode("ill", 4'hE);
        cyc("ill_exec", 1'b1, 1'b0, 1'b0, E_ILL);

        fetch_decode("ldi", 4'h9);
        cyc("ldi_exec", 1'b1, 1'b0, 1'b0, E_PASSB);
        cyc("ldi_wb", 1'b1, 1'b0, 1'b0, E_WB_ALU);
        fetch_decode("noti", 4'hA);
        cyc("noti_exec", 1'b1, 1'b0, 1'b0, E_NOT);
        cyc("noti_wb", 1'b1, 1'b0, 1'b0, E_WB_ALU);
        fetch_decode("sub", 4'h2);
        cyc("sub_exec", 1'b1, 1'b0, 1'b0, E_SUB);
        cyc("sub_wb", 1'b1, 1'b0, 1'b0, E_WB_ALU);
        fetch_decode("orr", 4'h3);
        cyc("orr_exec", 1'b1, 1'b0, 1'b0, E_OR);
        cyc("orr_wb", 1'b1, 1'b0, 1'b0, E_WB_ALU);
        fetch_decode("xorr", 4'h4);
        cyc("xorr_exec", 1'b1, 1'b0, 1'b0, E_XOR);
        cyc("xorr_wb", 1'b1, 1'b0, 1'b0, E_WB_ALU);

        fetch_decode("st", 4'h6);
        cyc("st_exec", 1'b1, 1'b0, 1'b0, E_NONE);
        cyc("st_wr_done", 1'b1, 1'b0, 1'b0, E_WR_OK);

        fetch_decode("hlt", 4'hB);
        cyc("hlt_exec", 1'b1, 1'b0, 1'b0, E_NONE);
        cyc("halt_stay0", 1'b1, 1'b0, 1'b0, E_HALT);
        cyc("halt_stay1", 1'b1, 1'b0, 1'b0, E_HALT);
        cyc("halt_resume", 1'b1, 1'b0, 1'b1, E_RESUME);

        // ST that never completes: 15 strobe cycles, then a single mem_err
        fetch_decode("st_to", 4'h6);
        cyc("st_to_exec", 1'b1, 1'b0, 1'b0, E_NONE);
        for (int i = 0; i < 15; i++) cyc("st_to_wait", 1'b0, 1'b0, 1'b0, E_WR_WAIT);
        cyc("st_to_err", 1'b0, 1'b0, 1'b0, E_MEMERR);
        cyc("st_to_halt", 1'b0, 1'b0, 1'b0, E_HALT);
        cyc("st_to_resume", 1'b1, 1'b0, 1'b1, E_RESUME);

        // ST completing on the last cycle before the watchdog fires
        fetch_decode("st_late", 4'h6);
        cyc("st_late_exec", 1'b1, 1'b0, 1'b0, E_NONE);
        for (int i = 0; i < 14; i++) cyc("st_late_wait", 1'b0, 1'b0, 1'b0, E_WR_WAIT);
        cyc("st_late_done", 1'b1, 1'b0, 1'b0, E_WR_OK);

        // Async reset in the middle of a write handshake
        fetch_decode("st_rst", 4'h6);
        cyc("st_rst_exec", 1'b1, 1'b0, 1'b0, E_NONE);
        cyc("st_rst_wait", 1'b0, 1'b0, 1'b0, E_WR_WAIT);
        bus.mem_ready = 1'b0;
        #2;
        check_eq("st_rst_pre", {18'd0, outs_w}, {18'd0, E_WR_WAIT});
        rst_n = 1'b0;
        #1;
        check_eq("st_rst_drop", {18'd0, outs_w}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("st_rst_hold", {18'd0, outs_w}, 32'd0);
        rst_n = 1'b1;
        cyc("rst_idle", 1'b1, 1'b0, 1'b0, E_NONE);
        cyc("rst_fetch_wait", 1'b0, 1'b0, 1'b0, E_F_WAIT);
        cyc("rst_fetch", 1'b1, 1'b0, 1'b0, E_F_OK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
